// File: rtl/ftch_imem_pkg.sv
// Packet types shared by the fetch stage and the instruction-memory responder.
package ftch_imem_pkg;

   typedef struct packed {
      logic [31:0] addr;
   } ftch_imem_pkt_t;

   typedef struct packed {
      logic [31:0] data;
   } imem_ftch_pkt_t;

endpackage

// File: rtl/imem_pkg.sv
// Local types and helpers for the instruction-memory responder.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RSP
   } imem_state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } imem_ld_pkt_t;

   // Byte address to word index; callers truncate to their array width.
   function automatic logic [31:0] word_idx(input logic [31:0] a);
      return a >> 2;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write, single-synchronous-read word array; write-first on collision.
module imem_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Read register is cleared by reset; the array itself is not.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
      end
   end

endmodule

// File: rtl/imem_rsp.sv
// Instruction-memory responder: answers a held fetch request after LATENCY
// cycles, restarting on address change and dropping on withdrawal.
module imem_rsp
   import ftch_imem_pkg::*;
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ftch_imem_vld,
   input  ftch_imem_pkt_t ftch_imem_pkt,
   output logic           imem_ftch_vld,
   output imem_ftch_pkt_t imem_ftch_pkt,
   input  logic           ld_vld,
   input  logic [31:0]    ld_addr,
   input  logic [31:0]    ld_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(LATENCY + 1);

   if (LATENCY < 1) begin : g_bad_latency
      $error("imem_rsp: LATENCY must be at least 1");
   end
   if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("imem_rsp: DEPTH_WORDS must be a power of 2");
   end

   imem_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  data_q;
   logic         rd_en;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] req_idx;
   logic [AW-1:0] ld_idx;
   logic         addr_hit;
   logic         accept;
   imem_ld_pkt_t ld_pkt;

   assign ld_pkt   = '{addr: ld_addr, data: ld_data};
   assign ld_idx   = AW'(word_idx(ld_pkt.addr));
   assign req_idx  = AW'(word_idx(req_addr_q));
   assign addr_hit = (ftch_imem_pkt.addr == req_addr_q);
   assign accept   = ftch_imem_vld && ((state_q == IDLE) || !addr_hit);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_addr_d    = req_addr_q;
      rd_en         = 1'b0;
      rd_idx        = req_idx;
      imem_ftch_vld = 1'b0;

      unique case (state_q)
         IDLE: ;
         WAIT: begin
            if (!ftch_imem_vld) begin
               state_d = IDLE;
            end else if (addr_hit) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = RSP;
                  rd_en   = 1'b1;
               end
            end
         end
         RSP: begin
            imem_ftch_vld = ftch_imem_vld && addr_hit;
            if (!ftch_imem_vld || addr_hit) begin
               state_d = IDLE;
            end
            // Keep the presented word coherent with loader writes to it.
            if (ld_vld && (ld_idx == req_idx)) begin
               rd_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh or restarted request overrides whatever the state decided.
      if (accept) begin
         req_addr_d = ftch_imem_pkt.addr;
         if (LATENCY == 1) begin
            state_d = RSP;
            rd_en   = 1'b1;
            rd_idx  = AW'(word_idx(ftch_imem_pkt.addr));
         end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_addr_q <= req_addr_d;
      end
   end

   imem_ram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_ram (
      .clk    (clk),
      .rst    (reset),
      .wr_en  (ld_vld),
      .wr_idx (ld_idx),
      .wr_data(ld_pkt.data),
      .rd_en  (rd_en),
      .rd_idx (rd_idx),
      .rd_data(data_q)
   );

   assign imem_ftch_pkt.data = data_q;

endmodule

// File: tb/tb_imem_rsp.sv
// Directed bench for imem_rsp at LATENCY 2 (vector table), 3 and 1 (sequences).
module tb_imem_rsp;
   import ftch_imem_pkg::*;

   logic           clk;
   logic           reset;
   logic           vld;
   ftch_imem_pkt_t req_pkt;
   logic           ld_vld;
   logic [31:0]    ld_addr;
   logic [31:0]    ld_data;
   logic           vld2, vld3, vld1;
   imem_ftch_pkt_t rsp2, rsp3, rsp1;

   int unsigned n_vec;
   int unsigned n_bad;

   imem_rsp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset), .ftch_imem_vld(vld), .ftch_imem_pkt(req_pkt),
      .imem_ftch_vld(vld2), .imem_ftch_pkt(rsp2),
      .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data));

   imem_rsp #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .ftch_imem_vld(vld), .ftch_imem_pkt(req_pkt),
      .imem_ftch_vld(vld3), .imem_ftch_pkt(rsp3),
      .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data));

   imem_rsp #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .ftch_imem_vld(vld), .ftch_imem_pkt(req_pkt),
      .imem_ftch_vld(vld1), .imem_ftch_pkt(rsp1),
      .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] addr;
      logic        lv;
      logic [31:0] la;
      logic [31:0] ld;
      logic        chk;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   function automatic vec_t v(logic rst, logic vl, logic [31:0] addr, logic lv,
                              logic [31:0] la, logic [31:0] ld, logic chk,
                              logic ev, logic [31:0] ed);
      vec_t r;
      r.rst = rst; r.vld = vl; r.addr = addr; r.lv = lv; r.la = la; r.ld = ld;
      r.chk = chk; r.ev = ev; r.ed = ed;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change just after the edge; outputs are sampled on the falling edge.
   task automatic step(input logic rst, input logic vl, input logic [31:0] addr,
                       input logic lv, input logic [31:0] la, input logic [31:0] ld);
      @(posedge clk);
      #1;
      reset = rst; vld = vl; req_pkt.addr = addr;
      ld_vld = lv; ld_addr = la; ld_data = ld;
      @(negedge clk);
   endtask

   vec_t tbl [34];

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1; vld = 1'b0; req_pkt.addr = '0;
      ld_vld = 1'b0; ld_addr = '0; ld_data = '0;

      // Row = one cycle: inputs for that cycle, expected LATENCY=2 outputs in it.
      tbl[0]  = v(1, 0, 32'h0,    0, 32'h0,  32'h0,        0, 0, 32'h0);
      tbl[1]  = v(1, 0, 32'h0,    0, 32'h0,  32'h0,        1, 0, 32'h0);
      tbl[2]  = v(0, 0, 32'h0,    1, 32'h20, 32'h8C010004, 1, 0, 32'h0);
      tbl[3]  = v(0, 0, 32'h0,    1, 32'h100,32'h11111111, 1, 0, 32'h0);
      tbl[4]  = v(0, 0, 32'h0,    1, 32'h4,  32'hAAAA0004, 1, 0, 32'h0);
      tbl[5]  = v(0, 0, 32'h0,    1, 32'h8,  32'hBBBB0008, 1, 0, 32'h0);
      tbl[6]  = v(0, 0, 32'h0,    1, 32'h0,  32'h55555555, 1, 0, 32'h0);
      tbl[7]  = v(0, 1, 32'h20,   0, 32'h0,  32'h0,        1, 0, 32'h0);
      tbl[8]  = v(0, 1, 32'h20,   0, 32'h0,  32'h0,        1, 0, 32'h0);
      tbl[9]  = v(0, 1, 32'h20,   0, 32'h0,  32'h0,        1, 1, 32'h8C010004);
      tbl[10] = v(0, 0, 32'h20,   0, 32'h0,  32'h0,        1, 0, 32'h8C010004);
      tbl[11] = v(0, 1, 32'h0,    0, 32'h0,  32'h0,        1, 0, 32'h8C010004);
      tbl[12] = v(0, 0, 32'h0,    0, 32'h0,  32'h0,        1, 0, 32'h8C010004);
      tbl[13] = v(0, 1, 32'h100,  0, 32'h0,  32'h0,        1, 0, 32'h8C010004);
      tbl[14] = v(0, 1, 32'h100,  0, 32'h0,  32'h0,        1, 0, 32'h8C010004);
      tbl[15] = v(0, 1, 32'h100,  0, 32'h0,  32'h0,        1, 1, 32'h11111111);
      tbl[16] = v(0, 0, 32'h100,  0, 32'h0,  32'h0,        1, 0, 32'h11111111);
      tbl[17] = v(0, 1, 32'h4,    0, 32'h0,  32'h0,        1, 0, 32'h11111111);
      tbl[18] = v(0, 1, 32'h8,    0, 32'h0,  32'h0,        1, 0, 32'h11111111);
      tbl[19] = v(0, 1, 32'h8,    0, 32'h0,  32'h0,        1, 0, 32'h11111111);
      tbl[20] = v(0, 1, 32'h8,    0, 32'h0,  32'h0,        1, 1, 32'hBBBB0008);
      tbl[21] = v(0, 0, 32'h8,    1, 32'h40, 32'h40404040, 1, 0, 32'hBBBB0008);
      tbl[22] = v(0, 1, 32'h40,   0, 32'h0,  32'h0,        1, 0, 32'hBBBB0008);
      tbl[23] = v(0, 1, 32'h40,   1, 32'h40, 32'hDEADBEEF, 1, 0, 32'hBBBB0008);
      tbl[24] = v(0, 1, 32'h40,   1, 32'h40, 32'hCAFEF00D, 1, 1, 32'hDEADBEEF);
      tbl[25] = v(0, 0, 32'h40,   0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[26] = v(0, 1, 32'h40,   0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[27] = v(0, 1, 32'h40,   0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[28] = v(0, 1, 32'h40,   0, 32'h0,  32'h0,        1, 1, 32'hCAFEF00D);
      tbl[29] = v(0, 0, 32'h40,   0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[30] = v(0, 1, 32'h1022, 0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[31] = v(0, 1, 32'h1022, 0, 32'h0,  32'h0,        1, 0, 32'hCAFEF00D);
      tbl[32] = v(0, 1, 32'h1022, 0, 32'h0,  32'h0,        1, 1, 32'h8C010004);
      tbl[33] = v(0, 0, 32'h1022, 0, 32'h0,  32'h0,        1, 0, 32'h8C010004);

      for (int i = 0; i < 34; i++) begin
         step(tbl[i].rst, tbl[i].vld, tbl[i].addr, tbl[i].lv, tbl[i].la, tbl[i].ld);
         if (tbl[i].chk) begin
            check($sformatf("l2_row%0d_vld", i), {31'b0, vld2}, {31'b0, tbl[i].ev});
            check($sformatf("l2_row%0d_data", i), rsp2.data, tbl[i].ed);
         end
      end

      // LATENCY=3: reset while waiting, then a clean request after release.
      step(0, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_req_idle_vld", {31'b0, vld3}, 32'h0);
      step(1, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_wait_vld", {31'b0, vld3}, 32'h0);
      step(1, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_rst_vld", {31'b0, vld3}, 32'h0);
      check("l3_rst_data", rsp3.data, 32'h0);
      step(0, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_r0_vld", {31'b0, vld3}, 32'h0);
      check("l3_r0_data", rsp3.data, 32'h0);
      step(0, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_r1_vld", {31'b0, vld3}, 32'h0);
      step(0, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_r2_vld", {31'b0, vld3}, 32'h0);
      step(0, 1, 32'h0, 0, 32'h0, 32'h0);
      check("l3_r3_vld", {31'b0, vld3}, 32'h1);
      check("l3_r3_data", rsp3.data, 32'h55555555);
      step(0, 0, 32'h0, 0, 32'h0, 32'h0);
      check("l3_after_vld", {31'b0, vld3}, 32'h0);

      // LATENCY=1: aliased and misaligned addresses hit the same word.
      step(0, 0, 32'h0, 1, 32'h4, 32'h12345678);
      check("l1_load_vld", {31'b0, vld1}, 32'h0);
      step(0, 1, 32'h1004, 0, 32'h0, 32'h0);
      check("l1_a0_vld", {31'b0, vld1}, 32'h0);
      step(0, 1, 32'h1004, 0, 32'h0, 32'h0);
      check("l1_a1_vld", {31'b0, vld1}, 32'h1);
      check("l1_a1_data", rsp1.data, 32'h12345678);
      step(0, 1, 32'h6, 0, 32'h0, 32'h0);
      check("l1_b0_vld", {31'b0, vld1}, 32'h0);
      step(0, 1, 32'h6, 0, 32'h0, 32'h0);
      check("l1_b1_vld", {31'b0, vld1}, 32'h1);
      check("l1_b1_data", rsp1.data, 32'h12345678);
      step(0, 1, 32'h1020, 0, 32'h0, 32'h0);
      check("l1_c0_vld", {31'b0, vld1}, 32'h0);
      step(0, 1, 32'h1020, 0, 32'h0, 32'h0);
      check("l1_c1_vld", {31'b0, vld1}, 32'h1);
      check("l1_c1_data", rsp1.data, 32'h8C010004);
      step(0, 0, 32'h0, 0, 32'h0, 32'h0);
      check("l1_after_vld", {31'b0, vld1}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_rsp.md
Name: imem_rsp

Overview:
- Instruction-memory responder. This is the far end of the ftch_imem request/response interface that the fetch stage drives.
- Accepts a held fetch request (vld + addr) and returns the 32-bit instruction word after a fixed, parameterised latency. It drops or restarts the request if fetch withdraws it or changes its address.
- Includes a word-write loader port so the bench or boot logic can preload program contents.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Must be a power of 2.
- LATENCY, 2: cycles from first sighting of a request to imem_ftch_vld. Must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ftch_imem_vld  in  1  fetch request valid. Held until serviced or withdrawn.
- ftch_imem_pkt  in  ftch_imem_pkg::ftch_imem_pkt_t (32)  .addr = byte address of the instruction.
- imem_ftch_vld  out  1  response valid.
- imem_ftch_pkt  out  ftch_imem_pkg::imem_ftch_pkt_t (32)  .data = instruction word.
- ld_vld  in  1  loader write enable.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader write data.

Behaviour:
- Index function: idx(a) = a[$clog2(DEPTH_WORDS)+1:2].
  - a[1:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Reset (sync, high), values on the next edge:
  - state=IDLE, cnt=0, req_addr_q=0, data_q=0.
  - imem_ftch_vld=0, imem_ftch_pkt.data=0.
  - Array contents are not reset.
  - Reset mid-operation discards any in-flight request silently.
- States: IDLE, WAIT, RSP.
- Accept event: occurs when ftch_imem_vld=1 and either (a) state=IDLE, or (b) state is WAIT/RSP and ftch_imem_pkt.addr ≠ req_addr_q (restart). On accept:
  - req_addr_q <= addr.
  - If LATENCY=1: go to RSP and load data_q.
  - Otherwise: cnt <= LATENCY-1 and go to WAIT.
- WAIT:
  - ftch_imem_vld=0: go to IDLE (request abandoned, e.g. fetch redirect).
  - Same addr held: cnt decrements. When cnt==1, go to RSP and load data_q <= mem[idx(req_addr_q)].
- RSP:
  - imem_ftch_vld = ftch_imem_vld & (ftch_imem_pkt.addr == req_addr_q). This is combinational on the inputs.
  - There is no ready signal: fetch consumes in the cycle vld is high.
  - After a completed handshake, go to IDLE. A new request may be accepted the following cycle.
  - ftch_imem_vld=0: go to IDLE.
- Latency: request first presented in cycle T and held gives imem_ftch_vld=1 in cycle T+LATENCY. Back-to-back throughput is one response per LATENCY+1 cycles.
- imem_ftch_vld is 0 in IDLE and WAIT.
- imem_ftch_pkt.data = data_q at all times.
- Loader writes:
  - ld_vld=1 writes mem[idx(ld_addr)] <= ld_data at the edge. Writes are independent of state.
  - Write-first: if a write and the data_q load hit the same idx in the same cycle, data_q gets ld_data.
  - If a write hits idx(req_addr_q) while in RSP, data_q is updated too, so the response always reflects the latest array contents.
- Counter width: $clog2(LATENCY+1).
- Elaboration-time assertions: LATENCY≥1, DEPTH_WORDS power of 2.

Decomposition:
- ftch_imem_pkg (existing): both packet typedefs. No changes.
- New imem_pkg:
  - imem_state_e enum (IDLE/WAIT/RSP).
  - imem_ld_pkt_t (addr, data) for the loader.
  - Word-index helper function.
- One sub-module, imem_ram:
  - Parameterised DEPTH_WORDS array.
  - One write port, one synchronous read port, write-first on collision.
- The FSM, counter and address compare stay in imem_rsp.

Test Plan:
- LATENCY=2: load 0x20←0x8C010004. Hold vld with addr=0x20 from cycle T → imem_ftch_vld=1 only at T+2 with data=0x8C010004. Drop vld at T+3 → vld 0, state IDLE.
- Withdraw: request 0x0 at T, vld=0 at T+1, request 0x100 from T+2 (mem[0x100]=0x11111111) → single response at T+4 with data 0x11111111. No response carries mem[0x0].
- Address change mid-WAIT: vld held, addr 0x4 at T, 0x8 from T+1 (mem[0x4]=0xAAAA0004, mem[0x8]=0xBBBB0008) → response at T+3 with 0xBBBB0008. 0xAAAA0004 never appears with vld=1.
- Write collision: ld write 0xDEADBEEF to 0x40 in the same cycle data_q loads for addr 0x40 → response data 0xDEADBEEF. A write during RSP to 0x40 changes data the next cycle.
- Reset mid-WAIT (LATENCY=3): reset high at T+1 → imem_ftch_vld=0, data=0 through reset. Request 0x0 presented after reset release at cycle R → response at R+3.
- Aliasing and LATENCY=1 (DEPTH=1024): mem[0x4]=0x12345678. Requests 0x1004, then 0x6 → each returns 0x12345678 one cycle after presentation, with responses two cycles apart.
